// File: rtl/picorv32_mem_responder.sv
// ============================================================================
// picorv32_mem_responder: PicoRV32 native-bus memory model with programmable
// latency, wait-state injection and sticky error reporting.
// Revision: 1.0
// ============================================================================
`default_nettype none

module picorv32_mem_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          LATENCY   = 2
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  input  logic        mem_stall,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        mem_error,
  output logic        protocol_error
);

  localparam int AW = (MEM_WORDS < 2) ? 1 : $clog2(MEM_WORDS);
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_wait = 2'd1;
  localparam logic [1:0] c_resp = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          instr_q, instr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          mem_error_q, mem_error_d;
  logic          protocol_error_q, protocol_error_d;

  logic [31:0] mem [MEM_WORDS];

  // Index/range of the request about to be (or already) latched, and of the held one
  logic [31:0] req_idx, lat_idx;
  logic        req_ok, lat_ok;

  always_comb begin
    req_idx = (addr_d - BASE_ADDR) >> 2;
    req_ok  = (req_idx < 32'(MEM_WORDS)) && (addr_d[1:0] == 2'b00);
    lat_idx = (addr_q - BASE_ADDR) >> 2;
    lat_ok  = (lat_idx < 32'(MEM_WORDS)) && (addr_q[1:0] == 2'b00);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q          <= c_idle;
      cnt_q            <= '0;
      instr_q          <= 1'b0;
      addr_q           <= '0;
      wdata_q          <= '0;
      wstrb_q          <= '0;
      rdata_q          <= '0;
      mem_error_q      <= 1'b0;
      protocol_error_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      instr_q          <= instr_d;
      addr_q           <= addr_d;
      wdata_q          <= wdata_d;
      wstrb_q          <= wstrb_d;
      rdata_q          <= rdata_d;
      mem_error_q      <= mem_error_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cnt_d            = cnt_q;
    instr_d          = instr_q;
    addr_d           = addr_q;
    wdata_d          = wdata_q;
    wstrb_d          = wstrb_q;
    mem_error_d      = mem_error_q;
    protocol_error_d = protocol_error_q;
    case (state_q)
      c_idle: begin
        if (mem_valid) begin
          instr_d = mem_instr;
          addr_d  = mem_addr;
          wdata_d = mem_wdata;
          wstrb_d = mem_wstrb;
          cnt_d   = CW'(LATENCY);
          state_d = (LATENCY == 0) ? c_resp : c_wait;
        end
      end
      c_wait: begin
        // The counter holds remaining wait cycles; the last one moves to RESP
        if (!mem_stall) begin
          if (cnt_q <= CW'(1)) begin
            cnt_d   = '0;
            state_d = c_resp;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      c_resp: begin
        state_d = c_idle;
        if (!lat_ok) mem_error_d = 1'b1;
      end
      default: state_d = c_idle;
    endcase

    if ((state_q == c_wait || state_q == c_resp) &&
        (!mem_valid || mem_instr != instr_q || mem_addr != addr_q ||
         mem_wdata != wdata_q || mem_wstrb != wstrb_q))
      protocol_error_d = 1'b1;

    // Read data is captured on entry to RESP and is zero in every other cycle
    rdata_d = '0;
    if (state_d == c_resp && req_ok && wstrb_d == 4'h0)
      rdata_d = mem[req_idx[AW-1:0]];
  end

  always_comb begin
    mem_ready      = (state_q == c_resp);
    mem_rdata      = rdata_q;
    mem_error      = mem_error_q;
    protocol_error = protocol_error_q;
  end

  always_ff @(posedge clock) begin
    if (resetn && state_q == c_resp && lat_ok) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[lat_idx[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/picorv32_mem_responder.md
PICORV32_MEM_RESPONDER -- requirements
Module: picorv32_mem_responder

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 1024: number of 32-bit words of backing store.
REQ-002 The block SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 The block SHALL have parameter LATENCY, default 2: wait cycles between request acceptance and response when no stall is applied.
REQ-004 The block SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1: reset, synchronous, active-low.
REQ-006 The block SHALL have port mem_valid, input, 1: request pending, from the core.
REQ-007 The block SHALL have port mem_instr, input, 1: request is an instruction fetch.
REQ-008 The block SHALL have port mem_addr, input, 32: byte address.
REQ-009 The block SHALL have port mem_wdata, input, 32: write data.
REQ-010 The block SHALL have port mem_wstrb, input, 4: byte write enables; 0 means read.
REQ-011 The block SHALL have port mem_stall, input, 1: extra wait-state injection for verification.
REQ-012 The block SHALL have port mem_ready, output, 1: one-cycle response strobe.
REQ-013 The block SHALL have port mem_rdata, output, 32: read data, valid while mem_ready=1.
REQ-014 The block SHALL have port mem_error, output, 1: sticky; out-of-range or misaligned access completed.
REQ-015 The block SHALL have port protocol_error, output, 1: sticky; core violated the request-hold rule.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESP.
REQ-017 In IDLE with mem_valid=1, the block SHALL latch mem_instr, mem_addr, mem_wdata and mem_wstrb, load the wait counter with LATENCY, and go to WAIT, or go directly to RESP when LATENCY=0.
REQ-018 In WAIT, the counter SHALL decrement only on cycles with mem_stall=0; when the counter is 0 and mem_stall=0, the FSM SHALL go to RESP.
REQ-019 Without stall, mem_ready SHALL be 1 exactly LATENCY+1 cycles after the first cycle mem_valid is seen in IDLE; each mem_stall=1 cycle in WAIT SHALL add one cycle.
REQ-020 mem_ready SHALL be 1 only in RESP, for exactly one cycle; RESP SHALL always go to IDLE.
REQ-021 A new request MAY be accepted in the IDLE cycle immediately after RESP, giving a minimum request-to-request spacing of LATENCY+2 cycles.
REQ-022 Word index SHALL be (addr-BASE_ADDR)>>2 computed modulo 2^32; an access is in range iff the index is below MEM_WORDS and addr[1:0]=0.
REQ-023 For a read in range, mem_rdata in RESP SHALL equal the stored word, sampled on entry to RESP.
REQ-024 For a write in range, each byte lane i with wstrb[i]=1 SHALL be updated at the RESP edge; other lanes SHALL be unchanged; mem_rdata SHALL be 0.
REQ-025 An out-of-range or misaligned access SHALL return mem_rdata=0, SHALL leave memory unmodified, and SHALL set mem_error at the RESP edge.
REQ-026 mem_rdata SHALL be 0 whenever mem_ready=0.
REQ-027 In WAIT or RESP, protocol_error SHALL be set if mem_valid=0, or if mem_instr, mem_addr, mem_wdata or mem_wstrb differ from the latched values.
REQ-028 Responses SHALL use the latched request, never the live inputs.
REQ-029 mem_stall SHALL be ignored in IDLE and RESP.
REQ-030 Memory contents SHALL be undefined after power-up; the block SHALL NOT define any initialisation.

Reset
REQ-031 When resetn=0 at a clock edge, the FSM SHALL go to IDLE, with mem_ready=0, mem_rdata=0, mem_error=0, protocol_error=0 and counter=0.
REQ-032 Reset SHALL take priority over all other activity.
REQ-033 A reset during WAIT or RESP SHALL abort the transfer with no memory write.
REQ-034 Memory contents SHALL NOT be affected by reset.
REQ-035 A request present in the first cycle after reset release SHALL be accepted normally.

Verification
REQ-036 Write then read, LATENCY=2: write addr 0x10, wdata 0xA5A5_1234, wstrb 0xF, mem_valid rises cycle 0 -> mem_ready=1 in cycle 3 only; then read 0x10 -> mem_rdata=0xA5A5_1234 in its response cycle.
REQ-037 Byte lanes: word 0x0 = 0x1122_3344, write wdata 0xFFFF_FFFF with wstrb 0x5 -> subsequent read returns 0x11FF_33FF.
REQ-038 Stall: LATENCY=2, mem_stall=1 for 3 cycles during WAIT -> mem_ready in cycle 6 instead of 3; no protocol_error.
REQ-039 Errors: read 0x1002 -> mem_rdata=0 and mem_error=1; with MEM_WORDS=1024, write 0x1000 -> memory unmodified and mem_error=1; mem_error stays 1 until reset.
REQ-040 Protocol: mem_addr changes from 0x20 to 0x24 while in WAIT -> protocol_error=1 next cycle; response still uses 0x20.
REQ-041 Reset mid-write: resetn=0 in WAIT of write 0x8 -> mem_ready never asserted, word 0x8 unchanged, all outputs 0 the cycle after reset.
